ntt_ctrl: RTL and testbench

NTT_CTRL -- requirements
Module: ntt_ctrl

---
 rtl/ntt_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ntt_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: address/strobe sequencer for an in-place 256-point forward NTT.
// Walks 7 layers x 128 butterflies, each as READ -> WAIT(BF_LAT) -> WRITE,
// driving a dual-port coefficient RAM and an external butterfly datapath.
// All outputs are registered, so they lag the FSM state by one cycle.
// Because of that lag, RAM read data lines up with the first WAIT cycle.
module ntt_ctrl #(
  parameter int DEPTH  = 8,
  parameter int BF_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] addr_1,
  output logic [DEPTH-1:0] addr_2,
  output logic             we_1,
  output logic             we_2,
  output logic             bf_en,
  output logic [6:0]       zeta_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(BF_LAT - 1);

  state_t     state_reg, state_next;
  logic [2:0] layer_reg, layer_next;
  logic [6:0] b_reg, b_next;
  logic [3:0] wait_cnt_reg, wait_cnt_next;

  // Output register stage and the values it loads next.
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [DEPTH-1:0] addr_1_reg, addr_1_next;
  logic [DEPTH-1:0] addr_2_reg, addr_2_next;
  logic             we_reg, we_next;
  logic             bf_en_reg, bf_en_next;
  logic [6:0]       zeta_reg, zeta_next;

  // Butterfly index math for the current (layer, b).
  logic [7:0] len;
  logic [7:0] hi_mask;
  logic [7:0] j_idx;
  logic [7:0] j_pair;
  logic [6:0] grp;
  logic [6:0] zeta_cur;
  logic       active;

  // j keeps the low L bits of b and shifts the group number up by one bit,
  // which is the same as adding the high (group) part of b to itself.
  always_comb begin
    len      = 8'd128 >> layer_reg;
    hi_mask  = ~(len - 8'd1);
    j_idx    = {1'b0, b_reg} + ({1'b0, b_reg} & hi_mask);
    j_pair   = j_idx + len;
    grp      = 7'({1'b0, b_reg} >> (3'd7 - layer_reg));
    zeta_cur = (7'd1 << layer_reg) + grp;
  end

  // State and loop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      layer_reg    <= 3'd0;
      b_reg        <= 7'd0;
      wait_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      layer_reg    <= layer_next;
      b_reg        <= b_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next-state and counter advance.
  always_comb begin
    state_next    = state_reg;
    layer_next    = layer_reg;
    b_next        = b_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_READ;
          layer_next = 3'd0;
          b_next     = 7'd0;
        end
      end
      S_READ: begin
        state_next    = S_WAIT;
        wait_cnt_next = 4'd0;
      end
      S_WAIT: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          state_next    = S_WRITE;
          wait_cnt_next = 4'd0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end
      S_WRITE: begin
        if (b_reg == 7'd127 && layer_reg == 3'd6) begin
          state_next = S_DONE;
          layer_next = 3'd0;
          b_next     = 7'd0;
        end else if (b_reg == 7'd127) begin
          state_next = S_READ;
          layer_next = layer_reg + 3'd1;
          b_next     = 7'd0;
        end else begin
          state_next = S_READ;
          b_next     = b_reg + 7'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state; addresses are zero outside a butterfly.
  always_comb begin
    active      = (state_reg == S_READ) || (state_reg == S_WAIT) || (state_reg == S_WRITE);
    busy_next   = active;
    done_next   = (state_reg == S_DONE);
    we_next     = (state_reg == S_WRITE);
    bf_en_next  = (state_reg == S_WAIT) && (wait_cnt_reg == 4'd0);
    addr_1_next = active ? DEPTH'(j_idx)  : '0;
    addr_2_next = active ? DEPTH'(j_pair) : '0;
    zeta_next   = active ? zeta_cur       : 7'd0;
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      addr_1_reg <= '0;
      addr_2_reg <= '0;
      we_reg     <= 1'b0;
      bf_en_reg  <= 1'b0;
      zeta_reg   <= 7'd0;
    end else begin
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      addr_1_reg <= addr_1_next;
      addr_2_reg <= addr_2_next;
      we_reg     <= we_next;
      bf_en_reg  <= bf_en_next;
      zeta_reg   <= zeta_next;
    end
  end

  // Write enables are masked by reset so an aborted WRITE never reaches RAM.
  always_comb begin
    busy     = busy_reg;
    done     = done_reg;
    addr_1   = addr_1_reg;
    addr_2   = addr_2_reg;
    we_1     = we_reg & ~rst;
    we_2     = we_reg & ~rst;
    bf_en    = bf_en_reg;
    zeta_idx = zeta_reg;
  end

endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: three instances (BF_LAT = 1, 2, 5) share start/rst.
// A write scoreboard, a RAM + butterfly model and a golden NTT check them.
module tb_ntt_ctrl;

  localparam int Q = 3329;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy     [3];
  logic       done     [3];
  logic [7:0] addr_1   [3];
  logic [7:0] addr_2   [3];
  logic       we_1     [3];
  logic       we_2     [3];
  logic       bf_en    [3];
  logic [6:0] zeta_idx [3];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      ntt_ctrl #(
        .DEPTH (8),
        .BF_LAT(gi == 0 ? 1 : (gi == 1 ? 2 : 5))
      ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy[gi]),
        .done    (done[gi]),
        .addr_1  (addr_1[gi]),
        .addr_2  (addr_2[gi]),
        .we_1    (we_1[gi]),
        .we_2    (we_2[gi]),
        .bf_en   (bf_en[gi]),
        .zeta_idx(zeta_idx[gi])
      );
    end
  endgenerate

  int lat_tab  [3] = '{1, 2, 5};
  int exp_done [3] = '{2689, 3585, 6273};

  // Shared bench state
  int cyc = 0;
  int zeta_tab [128];
  int golden   [256];
  int ram      [3][256];
  int dout1    [3];
  int dout2    [3];
  int hold1    [3];
  int hold2    [3];
  int load_gen  = 0;
  int load_seen = 0;

  typedef struct {
    int a1;
    int a2;
    int z;
  } wr_t;

  typedef struct {
    bit busy;
    bit bf;
    bit we;
    int a1;
    int a2;
    int z;
  } vec_t;

  wr_t  exp_q [3][$];
  bit   armed   [3];
  int   acc_cyc;
  int   last_bf [3];
  int   wr_cnt  [3];
  vec_t vt      [7];

  int checks = 0;
  int errors = 0;

  function automatic int poly_val(int w);
    return (w * 37 + 5) % Q;
  endfunction

  // RAM with registered read, plus a butterfly model that captures on bf_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_gen != load_seen) begin
      for (int i = 0; i < 3; i++)
        for (int w = 0; w < 256; w++)
          ram[i][w] <= poly_val(w);
      load_seen <= load_gen;
    end else begin
      for (int i = 0; i < 3; i++) begin
        dout1[i] <= ram[i][addr_1[i]];
        dout2[i] <= ram[i][addr_2[i]];
        if (bf_en[i]) begin
          hold1[i] <= (dout1[i] + (zeta_tab[zeta_idx[i]] * dout2[i]) % Q) % Q;
          hold2[i] <= (dout1[i] + Q - (zeta_tab[zeta_idx[i]] * dout2[i]) % Q) % Q;
        end
        if (we_1[i]) ram[i][addr_1[i]] <= hold1[i];
        if (we_2[i]) ram[i][addr_2[i]] <= hold2[i];
      end
    end
  end

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected write sequence from the textbook Cooley-Tukey loop nest.
  task automatic arm_all();
    wr_t w;
    int  k;
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      k = 1;
      for (int len = 128; len >= 2; len = len / 2) begin
        for (int st = 0; st < 256; st += 2 * len) begin
          for (int j = st; j < st + len; j++) begin
            w.a1 = j;
            w.a2 = j + len;
            w.z  = k;
            exp_q[i].push_back(w);
          end
          k++;
        end
      end
      armed[i]  = 1'b1;
      wr_cnt[i] = 0;
      last_bf[i] = -100;
    end
    acc_cyc = cyc;
  endtask

  // Advance to the next falling edge and check every instance.
  task automatic tick();
    wr_t w;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        exp_q[i].delete();
        armed[i] = 1'b0;
        continue;
      end
      if (bf_en[i]) last_bf[i] = cyc;
      if (we_1[i] || we_2[i]) begin
        wr_cnt[i]++;
        chk(we_1[i] && we_2[i] && addr_1[i] != addr_2[i], "we_pair",
            {we_1[i], we_2[i], addr_1[i], addr_2[i]}, {1'b1, 1'b1, addr_1[i], addr_1[i] + 8'd1});
        if (exp_q[i].size() == 0) begin
          chk(1'b0, $sformatf("unexpected_write_dut%0d", i), int'(addr_1[i]), -1);
        end else begin
          w = exp_q[i].pop_front();
          chk(int'(addr_1[i]) == w.a1 && int'(addr_2[i]) == w.a2 && int'(zeta_idx[i]) == w.z,
              $sformatf("write_dut%0d_a1_a2_z", i),
              int'(addr_1[i]) * 65536 + int'(addr_2[i]) * 256 + int'(zeta_idx[i]),
              w.a1 * 65536 + w.a2 * 256 + w.z);
          chk(cyc - last_bf[i] == lat_tab[i], $sformatf("bf_to_we_dut%0d", i),
              cyc - last_bf[i], lat_tab[i]);
        end
      end
      if (done[i]) begin
        chk(armed[i] && (cyc - acc_cyc == exp_done[i]) && exp_q[i].size() == 0,
            $sformatf("done_dut%0d", i), armed[i] ? cyc - acc_cyc : -1, exp_done[i]);
        armed[i] = 1'b0;
      end
      if (!busy[i]) begin
        chk(addr_1[i] == 8'd0 && addr_2[i] == 8'd0 && zeta_idx[i] == 7'd0 && !bf_en[i]
            && !we_1[i] && !we_2[i], $sformatf("idle_zero_dut%0d", i),
            int'(addr_1[i]) + int'(addr_2[i]) + int'(zeta_idx[i]) + int'(bf_en[i]), 0);
      end
    end
  endtask

  task automatic wait_all_done();
    int k = 0;
    while ((armed[0] || armed[1] || armed[2]) && k < 8000) begin
      tick();
      k++;
    end
    chk(!(armed[0] || armed[1] || armed[2]), "run_timeout", k, 8000);
  endtask

  task automatic load_ram();
    load_gen++;
    tick();
    tick();
  endtask

  task automatic check_ram();
    int bad;
    for (int i = 0; i < 3; i++) begin
      bad = 0;
      for (int w = 0; w < 256; w++)
        if (ram[i][w] != golden[w]) bad++;
      chk(bad == 0, $sformatf("ram_vs_golden_dut%0d_bad_words", i), bad, 0);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 3; i++) begin
      chk(!busy[i] && !done[i] && !we_1[i] && !we_2[i] && !bf_en[i] && addr_1[i] == 8'd0
          && addr_2[i] == 8'd0 && zeta_idx[i] == 7'd0, $sformatf("%s_dut%0d", name, i),
          int'(busy[i]) + int'(done[i]) + int'(bf_en[i]) + int'(addr_1[i]) + int'(addr_2[i])
          + int'(zeta_idx[i]), 0);
    end
  endtask

  initial begin
    int e, r, tt, k;
    int act, req;

    // Twiddles 17^bitrev7(k) mod q and the golden transform of the test polynomial.
    for (int i = 0; i < 128; i++) begin
      e = 0;
      for (int b = 0; b < 7; b++) e |= ((i >> b) & 1) << (6 - b);
      r = 1;
      for (int n = 0; n < e; n++) r = (r * 17) % Q;
      zeta_tab[i] = r;
    end
    for (int w = 0; w < 256; w++) golden[w] = poly_val(w);
    k = 1;
    for (int len = 128; len >= 2; len = len / 2) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          tt = (zeta_tab[k] * golden[j + len]) % Q;
          golden[j + len] = (golden[j] + Q - tt) % Q;
          golden[j]       = (golden[j] + tt) % Q;
        end
        k++;
      end
    end

    // First-butterfly trace for the BF_LAT=2 instance, one row per cycle after accept.
    vt[0] = '{0, 0, 0, 0,   0, 0};
    vt[1] = '{1, 0, 0, 0, 128, 1};
    vt[2] = '{1, 1, 0, 0, 128, 1};
    vt[3] = '{1, 0, 0, 0, 128, 1};
    vt[4] = '{1, 0, 1, 0, 128, 1};
    vt[5] = '{1, 0, 0, 1, 129, 1};
    vt[6] = '{1, 1, 0, 1, 129, 1};

    // Reset state
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) tick();
    check_all_zero("reset_with_start");
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check_all_zero("reset_state");

    // Full run, trace table and RAM result
    load_ram();
    start = 1'b1;
    tick();
    start = 1'b0;
    arm_all();
    for (int n = 0; n < 7; n++) begin
      act = {busy[1], bf_en[1], we_1[1]} * 16777216 + int'(addr_1[1]) * 65536
            + int'(addr_2[1]) * 256 + int'(zeta_idx[1]);
      req = {vt[n].busy, vt[n].bf, vt[n].we} * 16777216 + vt[n].a1 * 65536
            + vt[n].a2 * 256 + vt[n].z;
      chk(act == req, $sformatf("first_bf_row%0d", n), act, req);
      $display("row %0d: busy=%0d bf_en=%0d we=%0d addr_1=%0d addr_2=%0d zeta=%0d",
               n, busy[1], bf_en[1], we_1[1], addr_1[1], addr_2[1], zeta_idx[1]);
      tick();
    end
    wait_all_done();
    for (int i = 0; i < 3; i++) chk(wr_cnt[i] == 896, $sformatf("write_count_dut%0d", i), wr_cnt[i], 896);
    check_ram();

    // Extra start pulses mid-run must leave the trace untouched
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    arm_all();
    k = 0;
    while ((armed[0] || armed[1] || armed[2]) && k < 8000) begin
      start = (k == 10 || k == 500 || k == 2000);
      tick();
      k++;
    end
    start = 1'b0;
    chk(!(armed[0] || armed[1] || armed[2]), "spurious_run_timeout", k, 8000);
    for (int i = 0; i < 3; i++) chk(wr_cnt[i] == 896, $sformatf("spurious_write_count_dut%0d", i), wr_cnt[i], 896);
    repeat (50) tick();

    // Reset during WRITE of butterfly 300 on the BF_LAT=2 instance
    start = 1'b1;
    tick();
    start = 1'b0;
    arm_all();
    k = 0;
    while (wr_cnt[1] < 300 && k < 5000) begin
      tick();
      k++;
    end
    chk(wr_cnt[1] == 300, "reach_write_300", wr_cnt[1], 300);
    #1 rst = 1'b1;
    #1 chk(!we_1[1] && !we_2[1], "we_masked_by_rst", {we_1[1], we_2[1]}, 0);
    tick();
    check_all_zero("after_mid_reset");
    rst = 1'b0;
    k = 0;
    repeat (300) begin
      tick();
      if (done[0] || done[1] || done[2]) k++;
    end
    chk(k == 0, "no_done_after_reset", k, 0);

    // Clean transform after the aborted one
    load_ram();
    start = 1'b1;
    tick();
    start = 1'b0;
    arm_all();
    wait_all_done();
    check_ram();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
